sar_logic: RTL and testbench

// - SAR conversion controller for the 10-bit SAR ADC; sits directly downstream of the

---
 rtl/sar_logic.sv | 109 ++++++++++
 tb/tb_sar_logic.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sar_logic.sv
// sar_logic: SAR ADC controller that samples while CKS is high and runs an MSB-first binary search after CKS falls
module sar_logic #(
  parameter int NBIT = 10
) (
  input  logic            CK,
  input  logic            RSTN,
  input  logic            EN,
  input  logic            CKS,
  input  logic            COMP,
  output logic            SMP,
  output logic [NBIT-1:0] DAC,
  output logic [NBIT-1:0] DOUT,
  output logic            DVALID,
  output logic            BUSY,
  output logic            OVR
);
  localparam int IW = $clog2(NBIT);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONV} state_t;
  state_t state_q, state_d;
  logic cks_q, cks_d, smp_q, smp_d, dvalid_q, dvalid_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [NBIT-1:0] dac_q, dac_d, dout_q, dout_d, trial;
  logic [IW-1:0] idx_q, idx_d;
  logic rise, fall;
  assign rise = CKS & ~cks_q;
  assign fall = ~CKS & cks_q;
  assign SMP = smp_q;
  assign DAC = dac_q;
  assign DOUT = dout_q;
  assign DVALID = dvalid_q;
  assign BUSY = busy_q;
  assign OVR = ovr_q;
  always_comb begin
    state_d = state_q;
    cks_d = CKS;
    smp_d = smp_q;
    dac_d = dac_q;
    dout_d = dout_q;
    dvalid_d = 1'b0;
    busy_d = busy_q;
    ovr_d = 1'b0;
    idx_d = idx_q;
    trial = dac_q;
    if (!COMP) trial[idx_q] = 1'b0;
    if (!EN) begin
      state_d = IDLE;
      cks_d = 1'b0;
      smp_d = 1'b0;
      dac_d = '0;
      busy_d = 1'b0;
      idx_d = '0;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d = SAMPLE;
          smp_d = 1'b1;
          dac_d = '0;
        end
        SAMPLE: if (fall) begin
          state_d = CONV;
          smp_d = 1'b0;
          busy_d = 1'b1;
          dac_d = {1'b1, {(NBIT-1){1'b0}}};
          idx_d = IW'(NBIT-1);
        end
        CONV: if (rise) begin
          state_d = SAMPLE;
          smp_d = 1'b1;
          busy_d = 1'b0;
          dac_d = '0;
          ovr_d = 1'b1;
        end else if (idx_q != '0) begin
          dac_d = trial;
          dac_d[idx_q - 1'b1] = 1'b1;
          idx_d = idx_q - 1'b1;
        end else begin
          state_d = IDLE;
          dout_d = trial;
          dvalid_d = 1'b1;
          busy_d = 1'b0;
          dac_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cks_q <= 1'b0;
      smp_q <= 1'b0;
      dac_q <= '0;
      dout_q <= '0;
      dvalid_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      cks_q <= cks_d;
      smp_q <= smp_d;
      dac_q <= dac_d;
      dout_q <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_sar_logic.sv
// tb_sar_logic: ideal-comparator bench comparing sar_logic against expected SAR trial codes and results
module tb_sar_logic;
  logic CK = 1'b0;
  logic RSTN, EN, CKS, COMP, SMP, DVALID, BUSY, OVR;
  logic [9:0] DAC, DOUT, vin, exp_dout;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int dv_cyc = 0;
  int t0;
  sar_logic #(.NBIT(10)) dut (
    .CK(CK), .RSTN(RSTN), .EN(EN), .CKS(CKS), .COMP(COMP), .SMP(SMP),
    .DAC(DAC), .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY), .OVR(OVR)
  );
  always #5 CK = ~CK;
  assign COMP = (vin >= DAC);
  task automatic tick();
    @(negedge CK);
    cyc++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", tag, obs, want, cyc);
    end
  endtask
  function automatic logic [9:0] trial_code(input logic [9:0] code, input int n);
    int b, c;
    b = 9 - n;
    c = int'(code);
    return 10'(((c >> (b + 1)) << (b + 1)) | (1 << b));
  endfunction
  task automatic high_phase(input int len);
    CKS = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      check("smp_high", SMP, 1);
      if (i == 0) begin
        check("dac_clr", DAC, 0);
        check("busy_smp", BUSY, 0);
        check("dout_hold", DOUT, exp_dout);
      end
      check("dvalid_high", DVALID, 0);
    end
  endtask
  task automatic low_phase(input logic [9:0] code, input int len);
    vin = code;
    CKS = 1'b0;
    for (int n = 0; n < len; n++) begin
      tick();
      if (n < 10) begin
        check("dac_trial", DAC, trial_code(code, n));
        check("busy", BUSY, 1);
        check("smp_low", SMP, 0);
      end else if (n == 10) begin
        check("dvalid", DVALID, 1);
        check("dout", DOUT, code);
        check("busy_done", BUSY, 0);
        check("dac_idle", DAC, 0);
        exp_dout = code;
        dv_cyc = cyc;
      end
      if (n != 10) check("dvalid_low", DVALID, 0);
      check("ovr_low", OVR, 0);
    end
  endtask
  task automatic run_conv(input logic [9:0] code);
    high_phase(13);
    low_phase(code, 13);
  endtask
  task automatic check_quiet(input string tag, input logic [9:0] dout_want);
    check({tag, "_smp"}, SMP, 0);
    check({tag, "_dac"}, DAC, 0);
    check({tag, "_dvalid"}, DVALID, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_ovr"}, OVR, 0);
    check({tag, "_dout"}, DOUT, dout_want);
  endtask
  initial begin
    logic [9:0] codes [4];
    codes = '{10'h2A5, 10'h000, 10'h3FF, 10'h200};
    RSTN = 1'b0;
    EN = 1'b0;
    CKS = 1'b0;
    vin = '0;
    exp_dout = '0;
    repeat (2) tick();
    check_quiet("reset", 10'h000);
    RSTN = 1'b1;
    EN = 1'b1;
    tick();
    check_quiet("enable", 10'h000);
    foreach (codes[i]) run_conv(codes[i]);
    run_conv(10'h001);
    t0 = dv_cyc;
    run_conv(10'h3FE);
    check("dv_spacing1", dv_cyc - t0, 26);
    t0 = dv_cyc;
    run_conv(10'h155);
    check("dv_spacing2", dv_cyc - t0, 26);
    high_phase(13);
    low_phase(10'h0F0, 5);
    CKS = 1'b1;
    tick();
    check("abort_ovr", OVR, 1);
    check("abort_smp", SMP, 1);
    check("abort_dvalid", DVALID, 0);
    check("abort_dout", DOUT, exp_dout);
    check("abort_busy", BUSY, 0);
    check("abort_dac", DAC, 0);
    tick();
    check("abort_ovr_clr", OVR, 0);
    check("abort_smp_hold", SMP, 1);
    high_phase(11);
    low_phase(10'h3A7, 13);
    high_phase(13);
    low_phase(10'h123, 4);
    EN = 1'b0;
    tick();
    check_quiet("en_off", exp_dout);
    CKS = 1'b0;
    repeat (3) tick();
    check_quiet("en_idle", exp_dout);
    EN = 1'b1;
    run_conv(10'h2C4);
    high_phase(13);
    low_phase(10'h321, 4);
    RSTN = 1'b0;
    CKS = 1'b1;
    tick();
    check_quiet("midrst", 10'h000);
    exp_dout = '0;
    RSTN = 1'b1;
    CKS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("post_rst", 10'h000);
    end
    run_conv(10'h099);
    for (int i = 0; i < 12; i++) run_conv(10'($urandom_range(0, 1023)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
